// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-to-read bypass and a per-register
// busy scoreboard tracking in-flight producers between issue and writeback.
module regfile_mp_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*AW-1:0]    waddr,
    input  logic [NWR*XLEN-1:0]  wdata,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    output logic [AW:0]          busy_cnt
);

    localparam bit BYP = (BYPASS != 0);

    logic [XLEN-1:0] regs    [NREG];
    logic [XLEN-1:0] wr_val  [NREG];
    logic [NREG-1:0] wr_hit;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt_nxt;

    // Per-register write decode; ascending port order lets the highest-index
    // port win a collision. Disabled ports never match, so X addresses are inert.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (waddr[j*AW +: AW] == AW'(r))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wdata[j*XLEN +: XLEN];
                end
            end
        end
        wr_hit[0] = 1'b0;
    end

    // Issue outranks writeback: a newly issued producer supersedes the one completing.
    always_comb begin
        busy_nxt = busy;
        for (int r = 1; r < NREG; r++) begin
            if (iss_valid && (iss_rd == AW'(r)))
                busy_nxt[r] = 1'b1;
            else if (wr_hit[r])
                busy_nxt[r] = 1'b0;
        end
        busy_nxt[0] = 1'b0;
        cnt_nxt = '0;
        for (int r = 0; r < NREG; r++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[r]};
    end

    // NOTE: the array is built from flops rather than a RAM macro because reset
    // must clear every register asynchronously; a RAM could not honour that.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++)
                regs[r] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int r = 1; r < NREG; r++)
                if (wr_hit[r])
                    regs[r] <= wr_val[r];
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Outputs are forced low while resetn is held so bypass paths cannot leak through.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] ra;
            ra = raddr[i*AW +: AW];
            if (resetn && (ra != '0)) begin
                if (BYP && wr_hit[ra]) begin
                    rdata[i*XLEN +: XLEN] = wr_val[ra];
                    rbusy[i]              = 1'b0;
                end else begin
                    rdata[i*XLEN +: XLEN] = regs[ra];
                    rbusy[i]              = busy[ra];
                end
            end
        end
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file with write-to-read bypass and a per-register busy scoreboard.
- Sits between decode/issue and the writeback stage of the pipeline.
- Decode reads operands and busy status from it; issue marks destinations busy; writeback ports write results and clear busy.
- Replaces the fixed 2-read/1-write, 32x32 file.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; power of two, >= 2.
- AW, $clog2(NREG), register address width.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- BYPASS, 1, when 1, same-cycle writes forward to reads; when 0, reads return stored values only.

Ports:
- clk  input  1  clock; all state updates on posedge.
- resetn  input  1  asynchronous active-low reset.
- raddr  input  NRD*AW  read addresses; port i is bits [i*AW +: AW].
- rdata  output  NRD*XLEN  read data; port i is bits [i*XLEN +: XLEN].
- rbusy  output  NRD  1 = operand at port i still awaits a pending writeback.
- we  input  NWR  write enables.
- waddr  input  NWR*AW  write addresses.
- wdata  input  NWR*XLEN  write data.
- iss_valid  input  1  issue marks register iss_rd busy.
- iss_rd  input  AW  destination being issued.
- busy_cnt  output  AW+1  number of registers currently busy.

Behaviour:
- Reset:
  - resetn low asynchronously clears all NREG registers to 0, clears all busy bits and sets busy_cnt to 0.
  - With resetn low, rdata = 0 and rbusy = 0 on every port.
  - A reset asserted mid-operation discards all pending writes and issues.
- Register 0:
  - Reads as 0 and never reports busy.
  - Writes to address 0 are ignored.
  - iss_valid with iss_rd = 0 is ignored; busy bit 0 is constant 0.
- Writes:
  - Commit on posedge when we[j] = 1.
  - If several ports target the same address in one cycle, the highest-index port wins.
- Reads are combinational, zero latency:
  - BYPASS = 1: if any enabled write port targets raddr[i] (nonzero) this cycle, rdata[i] = wdata of the highest-index matching port; otherwise the stored value.
  - BYPASS = 0: always the stored value, so a value written at edge N is visible from cycle N+1.
- Busy scoreboard, per register r != 0, next state:
  - set, if iss_valid and iss_rd = r;
  - else clear, if any we[j] with waddr[j] = r;
  - else hold.
  - Issue and writeback to the same register in the same cycle leave it busy: a new producer supersedes the completing one.
  - Issue to an already-busy register leaves it busy; the count is unchanged.
- rbusy[i]:
  - BYPASS = 1: busy[raddr[i]] AND NOT (a write to raddr[i] is present this cycle).
  - BYPASS = 0: busy[raddr[i]] as stored.
  - Always 0 for address 0.
  - Issue in the current cycle does not affect rbusy until the next cycle.
- busy_cnt:
  - Registered; always equals the popcount of the busy bits after each edge.
  - Range 0..NREG-1.
  - Updated by the net +1 / -k of each edge; no overflow is possible.
- Writes to a non-busy register are legal: data updates and busy stays 0.
- X/unknown on addresses of disabled ports (we = 0, iss_valid = 0) must not affect any state or output.

Test Plan:
- Reset: write regs 1..31 with nonzero values, pulse resetn low mid-cycle (asynchronously) -> all rdata = 0, all rbusy = 0 and busy_cnt = 0 immediately, without waiting for a clock edge.
- Bypass: BYPASS=1, we[0]=1, waddr=5, wdata=0xDEADBEEF, raddr[0]=5 in the same cycle -> rdata[0] = 0xDEADBEEF that cycle; with BYPASS=0 -> the old value, then 0xDEADBEEF the next cycle.
- Write collision: we=2'b11, both ports target reg 7 with 0x11 and 0x22 -> reg 7 = 0x22 after the edge; a same-cycle bypass read also returns 0x22.
- Scoreboard:
  - Issue rd=3, then rd=4 -> busy_cnt = 2, and reads of 3 and 4 report rbusy = 1.
  - Writeback reg 3 -> rbusy = 0 for reg 3 that cycle (BYPASS=1), busy_cnt = 1 after the edge.
- Issue/writeback same cycle: reg 9 busy, iss_rd=9 plus we to 9 -> reg 9 stays busy, data updated, busy_cnt unchanged.
- x0: write 0xFFFFFFFF to address 0 and issue rd=0 -> rdata for address 0 = 0, rbusy = 0, busy_cnt unchanged.
